// File: rtl/reg_rename_file_pkg.sv
// Shared widths and helpers for the architectural register file with rename tags.
// Widths are provided here as localparams rather than in a separate define.v.
package reg_rename_file_pkg;

  localparam int DATALEN  = 32;
  localparam int REGINDEX = 5;
  localparam int ROBINDEX = 4;
  localparam int REGSIZE  = 32;

  // True when a request targets a real register; x0 absorbs every write.
  function automatic logic targets_reg(input logic                v,
                                       input logic [REGINDEX-1:0] rd);
    return v && (rd != {REGINDEX{1'b0}});
  endfunction

endpackage

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags: takes ROB commits,
// decoder renames and mispredict flushes, and serves two combinational source lookups.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int XLEN      = DATALEN,
  parameter int REG_NUM   = REGSIZE,
  parameter int ROB_IDX_W = ROBINDEX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd,
  input  logic [XLEN-1:0]      commit_value,
  input  logic [ROB_IDX_W-1:0] commit_rename,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [ROB_IDX_W-1:0] issue_rename,
  input  logic [4:0]           rs1_index,
  input  logic [4:0]           rs2_index,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_rename,
  output logic [XLEN-1:0]      rs1_value,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_rename,
  output logic [XLEN-1:0]      rs2_value,
  input  logic                 jump_wrong
);

  typedef struct packed {
    logic                 busy;
    logic [ROB_IDX_W-1:0] rename;
    logic [XLEN-1:0]      value;
  } lookup_t;

  logic [XLEN-1:0]      value_q [REG_NUM];
  logic [XLEN-1:0]      value_d [REG_NUM];
  logic                 busy_q  [REG_NUM];
  logic                 busy_d  [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_q   [REG_NUM];
  logic [ROB_IDX_W-1:0] tag_d   [REG_NUM];

  logic    commit_en_s;
  logic    issue_en_s;
  lookup_t rs1_s;
  lookup_t rs2_s;

  // A committing instruction completes its own pending rename only if it is still the
  // newest writer of that register; bypassing it lets the decoder skip one cycle of waiting.
  function automatic lookup_t lookup(input logic [4:0]           idx,
                                     input logic                 e_busy,
                                     input logic [ROB_IDX_W-1:0] e_tag,
                                     input logic [XLEN-1:0]      e_value,
                                     input logic                 c_valid,
                                     input logic [4:0]           c_rd,
                                     input logic [XLEN-1:0]      c_value,
                                     input logic [ROB_IDX_W-1:0] c_rename);
    lookup_t r;
    r = '0;
    if (idx == 5'd0) begin
      r = '0;
    end else if (c_valid && (c_rd == idx) && e_busy && (e_tag == c_rename)) begin
      r.busy   = 1'b0;
      r.rename = {ROB_IDX_W{1'b0}};
      r.value  = c_value;
    end else begin
      r.busy   = e_busy;
      r.rename = e_busy ? e_tag : {ROB_IDX_W{1'b0}};
      r.value  = e_value;
    end
    return r;
  endfunction

  assign commit_en_s = rdy && targets_reg(commit_valid, commit_rd);
  assign issue_en_s  = rdy && !jump_wrong && targets_reg(issue_valid, issue_rd);

  // Source lookups: pre-edge state plus commit bypass, never the same-cycle issue.
  always_comb begin
    rs1_s = lookup(rs1_index, busy_q[rs1_index], tag_q[rs1_index], value_q[rs1_index],
                   commit_valid, commit_rd, commit_value, commit_rename);
    rs2_s = lookup(rs2_index, busy_q[rs2_index], tag_q[rs2_index], value_q[rs2_index],
                   commit_valid, commit_rd, commit_value, commit_rename);
  end

  assign rs1_busy   = rs1_s.busy;
  assign rs1_rename = rs1_s.rename;
  assign rs1_value  = rs1_s.value;
  assign rs2_busy   = rs2_s.busy;
  assign rs2_rename = rs2_s.rename;
  assign rs2_value  = rs2_s.value;

  // Next state: commit writes value, flush clears renames, issue renames (wins over commit).
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      value_d[i] = value_q[i];
      busy_d[i]  = busy_q[i];
      tag_d[i]   = tag_q[i];
    end
    if (commit_en_s) begin
      value_d[commit_rd] = commit_value;
      if (tag_q[commit_rd] == commit_rename) begin
        busy_d[commit_rd] = 1'b0;
      end else begin
        busy_d[commit_rd] = busy_q[commit_rd];
      end
    end else begin
      value_d[0] = {XLEN{1'b0}};
    end
    if (rdy && jump_wrong) begin
      for (int i = 0; i < REG_NUM; i++) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = {ROB_IDX_W{1'b0}};
      end
    end else if (issue_en_s) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_rename;
    end else begin
      busy_d[0] = 1'b0;
    end
  end

  // State registers; rdy gating is folded into the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= {XLEN{1'b0}};
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= {ROB_IDX_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= value_d[i];
        busy_q[i]  <= busy_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: a register-level reference model checked every
// cycle, plus hand-computed literal expectations from the scenario list.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        commit_valid, issue_valid, jump_wrong;
  logic [4:0]  commit_rd, issue_rd, rs1_index, rs2_index;
  logic [31:0] commit_value;
  logic [3:0]  commit_rename, issue_rename;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_rename, rs2_rename;
  logic [31:0] rs1_value, rs2_value;

  int checks = 0;
  int errors = 0;
  bit model_live = 1'b0;

  // Reference model: plain per-register arrays.
  logic [31:0] m_val [32];
  logic        m_busy [32];
  logic [3:0]  m_tag [32];

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rename(commit_rename),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rename(issue_rename),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_busy(rs1_busy), .rs1_rename(rs1_rename), .rs1_value(rs1_value),
    .rs2_busy(rs2_busy), .rs2_rename(rs2_rename), .rs2_value(rs2_value),
    .jump_wrong(jump_wrong)
  );

  always #5 clk = ~clk;

  // Model state update, applying the architectural rules at each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0; m_busy[i] = 1'b0; m_tag[i] = 4'd0;
      end
      model_live = 1'b1;
    end else if (rdy) begin
      bit owner;
      owner = (m_tag[commit_rd] == commit_rename);
      if (commit_valid && commit_rd != 5'd0) begin
        m_val[commit_rd] = commit_value;
        if (owner) m_busy[commit_rd] = 1'b0;
      end
      if (jump_wrong) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = 4'd0;
        end
      end else if (issue_valid && issue_rd != 5'd0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rename;
      end
    end
  end

  function automatic logic [36:0] model_lookup(input logic [4:0] s);
    if (s == 5'd0) return 37'd0;
    if (commit_valid && commit_rd == s && m_busy[s] && m_tag[s] == commit_rename)
      return {1'b0, 4'd0, commit_value};
    return {m_busy[s], (m_busy[s] ? m_tag[s] : 4'd0), m_val[s]};
  endfunction

  // Every-cycle compare of both lookup ports against the model.
  always @(negedge clk) begin
    if (model_live && !rst) begin
      logic [36:0] e1, e2;
      e1 = model_lookup(rs1_index);
      e2 = model_lookup(rs2_index);
      checks++;
      if ({rs1_busy, rs1_rename, rs1_value} !== e1) begin
        errors++;
        $display("FAIL model_rs1 idx=%0d got=%h exp=%h", rs1_index,
                 {rs1_busy, rs1_rename, rs1_value}, e1);
      end
      checks++;
      if ({rs2_busy, rs2_rename, rs2_value} !== e2) begin
        errors++;
        $display("FAIL model_rs2 idx=%0d got=%h exp=%h", rs2_index,
                 {rs2_busy, rs2_rename, rs2_value}, e2);
      end
    end
  end

  task automatic idle();
    commit_valid = 1'b0; commit_rd = 5'd0; commit_value = 32'd0; commit_rename = 4'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rename = 4'd0;
    jump_wrong = 1'b0; rdy = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    commit_valid = 1'b1; commit_rd = rd; commit_rename = tag; commit_value = v;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] tag);
    issue_valid = 1'b1; issue_rd = rd; issue_rename = tag;
  endtask

  // Literal check of one port: {busy, rename, value}.
  task automatic check_lit(input string name, input int port, input logic b,
                           input logic [3:0] t, input logic [31:0] v);
    logic [36:0] got;
    #2;
    got = (port == 1) ? {rs1_busy, rs1_rename, rs1_value} : {rs2_busy, rs2_rename, rs2_value};
    checks++;
    if (got !== {b, t, v}) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, {b, t, v});
    end
  endtask

  initial begin
    idle();
    rst = 1'b1; rs1_index = 5'd5; rs2_index = 5'd0;
    tick(); tick();
    rst = 1'b0;
    check_lit("reset_rs1_x5", 1, 1'b0, 4'd0, 32'd0);
    check_lit("reset_rs2_x0", 2, 1'b0, 4'd0, 32'd0);

    issue(5'd3, 4'd7); rs1_index = 5'd3;
    check_lit("issue_not_visible_same_cycle", 1, 1'b0, 4'd0, 32'd0);
    tick(); idle();
    check_lit("x3_busy_tag7", 1, 1'b1, 4'd7, 32'd0);
    commit(5'd3, 4'd7, 32'hDEADBEEF);
    check_lit("x3_commit_bypass", 1, 1'b0, 4'd0, 32'hDEADBEEF);
    tick(); idle();
    check_lit("x3_after_commit", 1, 1'b0, 4'd0, 32'hDEADBEEF);

    rs1_index = 5'd4;
    issue(5'd4, 4'd2); tick(); idle();
    issue(5'd4, 4'd9); tick(); idle();
    commit(5'd4, 4'd2, 32'd11);
    check_lit("x4_stale_commit_no_bypass", 1, 1'b1, 4'd9, 32'd0);
    tick(); idle();
    check_lit("x4_stale_commit_keeps_busy", 1, 1'b1, 4'd9, 32'd11);
    commit(5'd4, 4'd9, 32'd22);
    check_lit("x4_owner_bypass", 1, 1'b0, 4'd0, 32'd22);
    tick(); idle();
    check_lit("x4_owner_commit", 1, 1'b0, 4'd0, 32'd22);

    commit(5'd6, 4'd1, 32'd5); issue(5'd6, 4'd3); rs1_index = 5'd6;
    tick(); idle();
    check_lit("x6_issue_wins_busy", 1, 1'b1, 4'd3, 32'd5);

    issue(5'd8, 4'd4); tick(); idle();
    issue(5'd10, 4'd5); tick(); idle();
    rs1_index = 5'd8; rs2_index = 5'd10;
    check_lit("x8_busy_pre_flush", 1, 1'b1, 4'd4, 32'd0);
    jump_wrong = 1'b1; commit(5'd1, 4'd0, 32'h100); issue(5'd12, 4'd6);
    tick(); idle();
    check_lit("x8_flushed", 1, 1'b0, 4'd0, 32'd0);
    check_lit("x10_flushed", 2, 1'b0, 4'd0, 32'd0);
    rs1_index = 5'd12; rs2_index = 5'd1;
    check_lit("x12_issue_ignored", 1, 1'b0, 4'd0, 32'd0);
    check_lit("x1_jal_write", 2, 1'b0, 4'd0, 32'h100);

    commit(5'd0, 4'd0, 32'hFF); issue(5'd0, 4'd5); rs1_index = 5'd0;
    check_lit("x0_no_bypass", 1, 1'b0, 4'd0, 32'd0);
    tick(); idle();
    check_lit("x0_stays_zero", 1, 1'b0, 4'd0, 32'd0);

    rdy = 1'b0; issue(5'd2, 4'd1); commit(5'd7, 4'd0, 32'h77); rs1_index = 5'd2; rs2_index = 5'd7;
    tick(); idle();
    check_lit("x2_rdy_low_no_issue", 1, 1'b0, 4'd0, 32'd0);
    check_lit("x7_rdy_low_no_commit", 2, 1'b0, 4'd0, 32'd0);

    issue(5'd9, 4'd3); rs1_index = 5'd9; tick(); idle();
    check_lit("x9_busy_before_rst", 1, 1'b1, 4'd3, 32'd0);
    rst = 1'b1; commit(5'd1, 4'd0, 32'h5); tick(); rst = 1'b0; idle();
    rs2_index = 5'd1;
    check_lit("x9_rst_clears_rename", 1, 1'b0, 4'd0, 32'd0);
    check_lit("x1_rst_clears_value", 2, 1'b0, 4'd0, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
